// File: rtl/packer_n_to_w_if.sv
// packer_n_to_w_if: bus between the lane receiver and the narrow-to-wide packer.
//   master : producer side (drives beats, observes packed words and status)
//   slave  : packer side
// Signals:
//   data_in    [IN_W-1:0]   input beat
//   valid_in                data_in valid this cycle
//   flush                   emit partial word (only with PACKER_FLUSH_EN defined)
//   data_out   [OUT_W-1:0]  packed word
//   valid_out               data_out valid for the current output slot
//   overflow                sticky, a completed word was dropped
//   fill_level              words currently buffered
// Optional feature macro: PACKER_FLUSH_EN (adds flush).
interface packer_n_to_w_if #(
  parameter int IN_W       = 8,
  parameter int RATIO      = 4,
  parameter int FIFO_DEPTH = 2
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [IN_W-1:0]  data_in;
  logic             valid_in;
`ifdef PACKER_FLUSH_EN
  logic             flush;
`endif
  logic [OUT_W-1:0] data_out;
  logic             valid_out;
  logic             overflow;
  logic [CNT_W-1:0] fill_level;

`ifdef PACKER_FLUSH_EN
  modport master (output data_in, valid_in, flush,
                  input  data_out, valid_out, overflow, fill_level);
  modport slave  (input  data_in, valid_in, flush,
                  output data_out, valid_out, overflow, fill_level);
`else
  modport master (output data_in, valid_in,
                  input  data_out, valid_out, overflow, fill_level);
  modport slave  (input  data_in, valid_in,
                  output data_out, valid_out, overflow, fill_level);
`endif
endinterface

// File: rtl/packer_n_to_w.sv
// packer_n_to_w: collects RATIO beats of IN_W bits into one OUT_W word, buffers
// completed words in a FIFO_DEPTH-entry FIFO and releases one word per output
// slot of OUT_PERIOD clk_4f cycles (emulating the slower clk_f domain).
// Ports:
//   clk_4f  fast clock, posedge
//   reset   synchronous, active-high
//   bus     packer_n_to_w_if.slave (beats in, packed words + status out)
// Parameters: IN_W, RATIO (>=2), FIFO_DEPTH (>=1, power of 2), OUT_PERIOD (>=1),
//   MSB_FIRST (1: beat 0 lands in the top lane, 0: beat 0 lands in bits [IN_W-1:0]).
// Optional feature macro: PACKER_FLUSH_EN (flush pushes a partial word).
module packer_n_to_w #(
  parameter int IN_W       = 8,
  parameter int RATIO      = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int OUT_PERIOD = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic            clk_4f,
  input  logic            reset,
  packer_n_to_w_if.slave  bus
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int SEL_W = $clog2(RATIO);
  localparam int PH_W  = (OUT_PERIOD > 1) ? $clog2(OUT_PERIOD) : 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(RATIO - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OUT_PERIOD - 1);
  localparam logic [AW-1:0]    PTR_LAST = AW'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // assembly
  logic [SEL_W-1:0]            sel;
  logic [RATIO-1:0][IN_W-1:0]  lane_q;
  logic [RATIO-1:0][IN_W-1:0]  lane_nxt;
  logic [RATIO-1:0]            lane_wr;
  logic [OUT_W-1:0]            word;
  logic                        beat, last_beat, flush_req, push;

  // fifo / slots
  logic [OUT_W-1:0]            mem [FIFO_DEPTH];
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [CNT_W-1:0]            count;
  logic [PH_W-1:0]             phase;
  logic                        slot_end, pop, push_ok;

  logic [OUT_W-1:0]            data_out_q;
  logic                        valid_out_q, overflow_q;

  assign beat      = bus.valid_in;
  assign last_beat = beat && (sel == SEL_LAST);

`ifdef PACKER_FLUSH_EN
  // A beat arriving with flush is captured first (via lane_nxt), so the
  // pushed word includes it; a flush with nothing collected does nothing.
  assign flush_req = bus.flush && ((sel != '0) || beat);
`else
  assign flush_req = 1'b0;
`endif

  assign push = last_beat || flush_req;

  // Per-lane assembly register. lane_nxt is the lane contents including a
  // beat landing this cycle, so the word pushed on the completing edge is
  // whole without waiting for the register update.
  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    assign lane_wr[i]  = beat && (sel == SEL_W'(i));
    assign lane_nxt[i] = lane_wr[i] ? bus.data_in : lane_q[i];

    always_ff @(posedge clk_4f) begin
      if (reset || push)   lane_q[i] <= '0;
      else if (lane_wr[i]) lane_q[i] <= bus.data_in;
    end

    if (MSB_FIRST) begin : g_msb
      assign word[OUT_W-1-i*IN_W -: IN_W] = lane_nxt[i];
    end else begin : g_lsb
      assign word[i*IN_W +: IN_W] = lane_nxt[i];
    end
  end

  assign slot_end = (phase == PH_LAST);
  assign pop      = slot_end && (count != '0);
  // Pop is evaluated first: a full FIFO still accepts when a slot drains it.
  assign push_ok  = push && ((count != CNT_FULL) || pop);

  always_ff @(posedge clk_4f) begin
    if (push_ok) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      sel         <= '0;
      phase       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (push)      sel <= '0;
      else if (beat) sel <= sel + 1'b1;

      phase <= slot_end ? '0 : phase + 1'b1;

      if (push_ok)   wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      else if (push) overflow_q <= 1'b1;

      if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;

      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Outputs only change at slot boundaries, so they hold a full slot.
      if (slot_end) begin
        valid_out_q <= pop;
        if (pop) data_out_q <= mem[rd_ptr];
      end
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.valid_out  = valid_out_q;
  assign bus.overflow   = overflow_q;
  assign bus.fill_level = count;
endmodule

// File: tb/tb_packer_n_to_w.sv
`timescale 1ns/1ps
// Bench for packer_n_to_w. Three instances share one 8-bit beat stream:
//   0: defaults, 1: MSB_FIRST=0, 2: OUT_PERIOD=8. A queue-based reference
// model (beat list + word queue per instance) predicts every output.
module tb_packer_n_to_w;
  localparam int N     = 3;
  localparam int RATIO = 4;
  localparam int DEPTH = 2;
  localparam int PER  [N] = '{4, 4, 8};
  localparam bit MSBF [N] = '{1'b1, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d;
  logic       v;
`ifdef PACKER_FLUSH_EN
  logic       f;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  packer_n_to_w_if #(.IN_W(8), .RATIO(RATIO), .FIFO_DEPTH(DEPTH)) if_a (), if_b (), if_c ();

  packer_n_to_w #(.IN_W(8), .RATIO(RATIO), .FIFO_DEPTH(DEPTH), .OUT_PERIOD(4), .MSB_FIRST(1'b1))
    u_a (.clk_4f(clk), .reset(rst), .bus(if_a.slave));
  packer_n_to_w #(.IN_W(8), .RATIO(RATIO), .FIFO_DEPTH(DEPTH), .OUT_PERIOD(4), .MSB_FIRST(1'b0))
    u_b (.clk_4f(clk), .reset(rst), .bus(if_b.slave));
  packer_n_to_w #(.IN_W(8), .RATIO(RATIO), .FIFO_DEPTH(DEPTH), .OUT_PERIOD(8), .MSB_FIRST(1'b1))
    u_c (.clk_4f(clk), .reset(rst), .bus(if_c.slave));

  assign if_a.data_in = d;  assign if_a.valid_in = v;
  assign if_b.data_in = d;  assign if_b.valid_in = v;
  assign if_c.data_in = d;  assign if_c.valid_in = v;
`ifdef PACKER_FLUSH_EN
  assign if_a.flush = f;  assign if_b.flush = f;  assign if_c.flush = f;
`endif

  logic [31:0] o_do [N];
  logic        o_vo [N];
  logic        o_ov [N];
  logic [1:0]  o_fl [N];
  assign o_do[0] = if_a.data_out; assign o_vo[0] = if_a.valid_out;
  assign o_ov[0] = if_a.overflow; assign o_fl[0] = if_a.fill_level;
  assign o_do[1] = if_b.data_out; assign o_vo[1] = if_b.valid_out;
  assign o_ov[1] = if_b.overflow; assign o_fl[1] = if_b.fill_level;
  assign o_do[2] = if_c.data_out; assign o_vo[2] = if_c.valid_out;
  assign o_ov[2] = if_c.overflow; assign o_fl[2] = if_c.fill_level;

  // ---------------- reference model ----------------
  logic [7:0]  m_beats [$];
  logic [31:0] m_q [N][$];
  logic [31:0] m_do [N];
  logic        m_vo [N];
  logic        m_ov [N];
  int          m_ph [N];
  int          cyc;      // edges since reset released

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_step();
    bit          do_push;
    logic [31:0] w;
    if (rst) begin
      m_beats.delete();
      cyc = 0;
      for (int k = 0; k < N; k++) begin
        m_q[k].delete();
        m_do[k] = '0; m_vo[k] = 1'b0; m_ov[k] = 1'b0; m_ph[k] = 0;
      end
    end else begin
      cyc++;
      for (int k = 0; k < N; k++) begin
        if (m_ph[k] == PER[k] - 1) begin
          if (m_q[k].size() > 0) begin
            m_do[k] = m_q[k].pop_front();
            m_vo[k] = 1'b1;
          end else begin
            m_vo[k] = 1'b0;
          end
        end
        m_ph[k] = (m_ph[k] + 1) % PER[k];
      end
      if (v) m_beats.push_back(d);
      do_push = (m_beats.size() == RATIO);
`ifdef PACKER_FLUSH_EN
      if (f && m_beats.size() > 0) do_push = 1'b1;
`endif
      if (do_push) begin
        for (int k = 0; k < N; k++) begin
          w = '0;
          for (int i = 0; i < m_beats.size(); i++)
            w |= MSBF[k] ? ({24'h0, m_beats[i]} << (8 * (RATIO - 1 - i)))
                         : ({24'h0, m_beats[i]} << (8 * i));
          if (m_q[k].size() < DEPTH) m_q[k].push_back(w);
          else                       m_ov[k] = 1'b1;
        end
        m_beats.delete();
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; v = 1'b1; d = 8'h5A;
    repeat (3) tick();
    v = 1'b0;
    for (int k = 0; k < N; k++) begin
      n_tests++; if (o_do[k] !== 32'h0) begin n_fail++; $display("FAIL reset_data_out[%0d] got %h want 0", k, o_do[k]); end
      n_tests++; if (o_vo[k] !== 1'b0)  begin n_fail++; $display("FAIL reset_valid_out[%0d] got %b want 0", k, o_vo[k]); end
      n_tests++; if (o_ov[k] !== 1'b0)  begin n_fail++; $display("FAIL reset_overflow[%0d] got %b want 0", k, o_ov[k]); end
      n_tests++; if (o_fl[k] !== 2'd0)  begin n_fail++; $display("FAIL reset_fill[%0d] got %0d want 0", k, o_fl[k]); end
    end
  endtask

  task automatic test_basic();
    logic [7:0] b [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    int n;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin v = 1'b1; d = b[i]; tick(); end
    v = 1'b0;
    n = 0;
    while (!o_vo[0] && n < 8) begin tick(); n++; end
    n_tests++; if (o_vo[0] !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1 (timeout)", o_vo[0]); end
    n_tests++; if (o_do[0] !== 32'hAABBCCDD) begin n_fail++; $display("FAIL basic_msb got %h want AABBCCDD", o_do[0]); end
    n_tests++; if (o_vo[1] !== 1'b1) begin n_fail++; $display("FAIL basic_lsb_valid got %b want 1", o_vo[1]); end
    n_tests++; if (o_do[1] !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL basic_lsb got %h want DDCCBBAA", o_do[1]); end
    n = 0;
    while (o_vo[0] && n < 10) begin tick(); n++; end
    n_tests++; if (n !== 4) begin n_fail++; $display("FAIL basic_valid_cycles got %0d want 4", n); end
    n_tests++; if (o_do[0] !== 32'hAABBCCDD) begin n_fail++; $display("FAIL basic_hold got %h want AABBCCDD", o_do[0]); end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [31:0] wa, wb;
    int n, cnt;
    for (int i = 0; i < 4; i++) begin v = 1'b1; d = 8'(i + 1); tick(); end
    v = 1'b0;
    n = 0;
    while (!o_vo[0] && n < 8) begin tick(); n++; end
    n_tests++; if (o_vo[0] !== 1'b1) begin n_fail++; $display("FAIL midslot_setup got %b want 1", o_vo[0]); end
    tick();
    rst = 1'b1; tick();
    n_tests++; if (o_vo[0] !== 1'b0) begin n_fail++; $display("FAIL midslot_valid got %b want 0", o_vo[0]); end
    n_tests++; if (o_do[0] !== 32'h0) begin n_fail++; $display("FAIL midslot_data got %h want 0", o_do[0]); end
    rst = 1'b0;
    v = 1'b1; d = 8'h11; tick(); d = 8'h22; tick(); v = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    cnt = 0; wa = '0; wb = '0;
    for (int c = 0; c < 30; c++) begin
      v = (c % 3 == 0) && (c < 12);
      d = v ? b[c / 3] : 8'h00;
      tick();
      if (o_vo[0]) begin cnt++; wa = o_do[0]; wb = o_do[1]; end
    end
    v = 1'b0;
    n_tests++; if (cnt !== 4) begin n_fail++; $display("FAIL midword_valid_cycles got %0d want 4", cnt); end
    n_tests++; if (wa !== 32'h11223344) begin n_fail++; $display("FAIL midword_msb got %h want 11223344", wa); end
    n_tests++; if (wb !== 32'h44332211) begin n_fail++; $display("FAIL midword_lsb got %h want 44332211", wb); end
    n_tests++; if (o_fl[0] !== 2'd0) begin n_fail++; $display("FAIL midword_fill got %0d want 0", o_fl[0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3];
    logic        vo_log [$];
    logic [31:0] do_log [$];
    int first;
    for (int i = 0; i < 3; i++) w[i] = $urandom;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 32; c++) begin
      if (c < 12) begin v = 1'b1; d = 8'(w[c / 4] >> (24 - 8 * (c % 4))); end
      else v = 1'b0;
      tick();
      vo_log.push_back(o_vo[0]);
      do_log.push_back(o_do[0]);
      for (int k = 0; k < N; k++) begin
        n_tests++;
        if ({o_do[k], o_vo[k], o_ov[k], o_fl[k]} !== {m_do[k], m_vo[k], m_ov[k], 2'(m_q[k].size())}) begin
          n_fail++;
          $display("FAIL b2b_model[%0d] got do=%h vo=%b ov=%b fl=%0d want do=%h vo=%b ov=%b fl=%0d",
                   k, o_do[k], o_vo[k], o_ov[k], o_fl[k], m_do[k], m_vo[k], m_ov[k], m_q[k].size());
        end
      end
    end
    v = 1'b0;
    first = -1;
    foreach (vo_log[j]) if (first < 0 && vo_log[j]) first = j;
    n_tests++;
    if (first < 0 || first + 12 >= vo_log.size()) begin
      n_fail++; $display("FAIL b2b_start got index %0d want 0..%0d", first, vo_log.size() - 13);
    end else begin
      for (int j = 0; j < 12; j++) begin
        n_tests++;
        if (vo_log[first + j] !== 1'b1 || do_log[first + j] !== w[j / 4]) begin
          n_fail++; $display("FAIL b2b_slot[%0d] got vo=%b do=%h want vo=1 do=%h", j, vo_log[first + j], do_log[first + j], w[j / 4]);
        end
      end
      n_tests++; if (vo_log[first + 12] !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b want 0", vo_log[first + 12]); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] sent [8];
    logic [31:0] got [$];
    bit seen_ov = 1'b0;
    int last = -1;
    for (int i = 0; i < 8; i++) sent[i] = {8'(i), 24'($urandom)};
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (c < 32) begin v = 1'b1; d = 8'(sent[c / 4] >> (24 - 8 * (c % 4))); end
      else v = 1'b0;
      tick();
      for (int k = 0; k < N; k++) begin
        n_tests++;
        if ({o_do[k], o_vo[k], o_ov[k], o_fl[k]} !== {m_do[k], m_vo[k], m_ov[k], 2'(m_q[k].size())}) begin
          n_fail++;
          $display("FAIL ovf_model[%0d] got do=%h vo=%b ov=%b fl=%0d want do=%h vo=%b ov=%b fl=%0d",
                   k, o_do[k], o_vo[k], o_ov[k], o_fl[k], m_do[k], m_vo[k], m_ov[k], m_q[k].size());
        end
      end
      n_tests++; if (o_fl[2] > 2'd2) begin n_fail++; $display("FAIL ovf_fill got %0d want <=2", o_fl[2]); end
      if (seen_ov) begin
        n_tests++; if (o_ov[2] !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", o_ov[2]); end
      end
      if (o_ov[2]) seen_ov = 1'b1;
      if (cyc % 8 == 0 && o_vo[2]) got.push_back(o_do[2]);
    end
    v = 1'b0;
    n_tests++; if (o_ov[2] !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", o_ov[2]); end
    n_tests++; if (o_ov[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_fast_slot got %b want 0", o_ov[0]); end
    n_tests++;
    if (got.size() == 0 || got.size() >= 8) begin n_fail++; $display("FAIL ovf_delivered got %0d words want 1..7", got.size()); end
    foreach (got[j]) begin
      int idx;
      idx = int'(got[j][31:24]);
      n_tests++;
      if (idx <= last || idx > 7 || got[j] !== sent[idx[2:0]]) begin
        n_fail++; $display("FAIL ovf_order[%0d] got %h (after index %0d) want next sent word in order", j, got[j], last);
      end
      last = idx;
    end
  endtask

`ifdef PACKER_FLUSH_EN
  task automatic test_flush();
    logic [7:0]  dt [9] = '{8'hAB, 8'hCD, 8'h00, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00};
    bit          vt [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bit          ft [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] got [$];
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c < 9) begin v = vt[c]; d = dt[c]; f = ft[c]; end
      else begin v = 1'b0; f = 1'b0; end
      tick();
      if (cyc % 4 == 0 && o_vo[0]) got.push_back(o_do[0]);
      for (int k = 0; k < N; k++) begin
        n_tests++;
        if ({o_do[k], o_vo[k], o_ov[k], o_fl[k]} !== {m_do[k], m_vo[k], m_ov[k], 2'(m_q[k].size())}) begin
          n_fail++;
          $display("FAIL flush_model[%0d] got do=%h vo=%b ov=%b fl=%0d want do=%h vo=%b ov=%b fl=%0d",
                   k, o_do[k], o_vo[k], o_ov[k], o_fl[k], m_do[k], m_vo[k], m_ov[k], m_q[k].size());
        end
      end
    end
    n_tests++;
    if (got.size() != 2) begin
      n_fail++; $display("FAIL flush_count got %0d words want 2", got.size());
    end else begin
      n_tests++; if (got[0] !== 32'hABCD0000) begin n_fail++; $display("FAIL flush_partial got %h want ABCD0000", got[0]); end
      n_tests++; if (got[1] !== 32'hEF010203) begin n_fail++; $display("FAIL flush_next got %h want EF010203", got[1]); end
    end
  endtask
`endif

  task automatic test_random();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      d   = 8'($urandom);
      rst = ($urandom_range(0, 199) == 0);
`ifdef PACKER_FLUSH_EN
      f   = ($urandom_range(0, 15) == 0);
`endif
      tick();
      for (int k = 0; k < N; k++) begin
        n_tests++;
        if ({o_do[k], o_vo[k], o_ov[k], o_fl[k]} !== {m_do[k], m_vo[k], m_ov[k], 2'(m_q[k].size())}) begin
          n_fail++;
          $display("FAIL rand_model[%0d] cyc=%0d got do=%h vo=%b ov=%b fl=%0d want do=%h vo=%b ov=%b fl=%0d",
                   k, c, o_do[k], o_vo[k], o_ov[k], o_fl[k], m_do[k], m_vo[k], m_ov[k], m_q[k].size());
        end
      end
    end
    v = 1'b0; rst = 1'b0;
`ifdef PACKER_FLUSH_EN
    f = 1'b0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    d = 8'h00; v = 1'b0; rst = 1'b1; cyc = 0;
`ifdef PACKER_FLUSH_EN
    f = 1'b0;
`endif
    test_reset();
    test_basic();
    test_reset_mid();
    test_back_to_back();
    test_overflow();
`ifdef PACKER_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
